// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit channel between NUM_REQ byte-stream
// requesters. Grants rotate round-robin and stay locked for a whole packet.
// Optional feature macro: UART_TX_ARB_HEADER_EN. When it is defined, each packet
// is preceded by a header byte {4'hA, 1'b0, owner[2:0]}.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [7:0]           tx_data,
   output logic                 tx_rdy,
   input  logic                 tx_ack,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id
);

`ifdef UART_TX_ARB_HEADER_EN
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, WAIT_LOW, HDR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_LOW} state_t;
`endif

   state_t               state_q, state_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [ID_W-1:0]      last_grant_q, last_grant_d;
   logic                 last_flag_q, last_flag_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_rdy_q, tx_rdy_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
`ifdef UART_TX_ARB_HEADER_EN
   // Marks that the handshake in flight carries the header, not payload.
   logic                 hdr_q, hdr_d;
`endif

   logic                 pick_found;
   logic [ID_W-1:0]      pick_id;
   logic [ID_W-1:0]      cand;
   logic [7:0]           sel_data;

   // Rotating priority: first valid requester after the previous owner.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   // Byte of the current owner.
   always_comb begin
      sel_data = req_data[8*int'(grant_q) +: 8];
   end

   // Next-state and output logic; req_ack defaults low so it only ever pulses.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      last_flag_d  = last_flag_q;
      tx_data_d    = tx_data_q;
      tx_rdy_d     = tx_rdy_q;
      req_ack_d    = '0;
`ifdef UART_TX_ARB_HEADER_EN
      hdr_d        = hdr_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_id;
`ifdef UART_TX_ARB_HEADER_EN
               state_d = HDR;
`else
               state_d = LOAD;
`endif
            end
         end
`ifdef UART_TX_ARB_HEADER_EN
         HDR: begin
            tx_data_d = {4'hA, 1'b0, 3'(grant_q)};
            tx_rdy_d  = 1'b1;
            hdr_d     = 1'b1;
            state_d   = WAIT_ACK;
         end
`endif
         LOAD: begin
            // Channel stays locked to grant_q even if the owner stalls.
            if (req_valid[grant_q]) begin
               tx_data_d          = sel_data;
               tx_rdy_d           = 1'b1;
               last_flag_d        = req_last[grant_q];
               req_ack_d[grant_q] = 1'b1;
               state_d            = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_ack) begin
               tx_rdy_d = 1'b0;
               state_d  = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            // A long ack must fall before the next byte can be offered.
            if (!tx_ack) begin
`ifdef UART_TX_ARB_HEADER_EN
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = LOAD;
               end else
`endif
               if (last_flag_q) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; requester 0 wins first after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         last_flag_q  <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_rdy_q     <= 1'b0;
         req_ack_q    <= '0;
`ifdef UART_TX_ARB_HEADER_EN
         hdr_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         last_flag_q  <= last_flag_d;
         tx_data_q    <= tx_data_d;
         tx_rdy_q     <= tx_rdy_d;
         req_ack_q    <= req_ack_d;
`ifdef UART_TX_ARB_HEADER_EN
         hdr_q        <= hdr_d;
`endif
      end
   end

   assign req_ack  = req_ack_q;
   assign tx_data  = tx_data_q;
   assign tx_rdy   = tx_rdy_q;
   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of single-byte arbitrations, hand
// sequences for multi-cycle corners, and randomized packet traffic checked
// against a packet-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
`ifdef UART_TX_ARB_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [8*NUM_REQ-1:0] req_data = '0;
   logic [NUM_REQ-1:0]   req_last = '0;
   logic [NUM_REQ-1:0]   req_ack;
   logic [7:0]           tx_data;
   logic                 tx_rdy;
   logic                 tx_ack = 1'b0;
   logic                 busy;
   logic [ID_W-1:0]      grant_id;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ack(req_ack), .tx_data(tx_data),
      .tx_rdy(tx_rdy), .tx_ack(tx_ack), .busy(busy), .grant_id(grant_id));

   typedef struct packed { logic [7:0] data; logic last; } rbyte_t;
   typedef struct packed { logic [7:0] data; logic [ID_W-1:0] id; logic hdr; } xfer_t;
   typedef struct {
      logic [NUM_REQ-1:0]   mask;
      logic [8*NUM_REQ-1:0] data;
      logic [ID_W-1:0]      exp_id;
      logic [7:0]           exp_byte;
   } vec_t;

   int     checks = 0;
   int     errors = 0;
   rbyte_t rq [NUM_REQ][$];
   bit     mid [NUM_REQ];
   xfer_t  exp_q[$], obs_q[$], pay_q[$];
   int     model_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ack = 1'b0;
      tick();
      chk("rst_tx_rdy", tx_rdy, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      rst = 1'b0;
      model_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) begin
         rq[i].delete();
         mid[i] = 1'b0;
      end
   endtask

   task automatic wait_rdy(input string name, output int n);
      n = 0;
      while (!tx_rdy && n < 50) begin
         tick();
         n++;
      end
      chk(name, tx_rdy, 1);
   endtask

   // Packet-level model: serve whole packets, next owner is the first requester
   // with queued data after the previous owner.
   task automatic build_expect();
      int pos [NUM_REQ];
      int owner, c;
      bit done;
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;
      forever begin
         owner = -1;
         for (int k = 1; k <= NUM_REQ; k++) begin
            c = (model_last + k) % NUM_REQ;
            if (owner < 0 && pos[c] < rq[c].size()) owner = c;
         end
         if (owner < 0) break;
         if (HDR_EN) exp_q.push_back('{data: 8'hA0 | 8'(owner), id: ID_W'(owner), hdr: 1'b1});
         done = 1'b0;
         while (!done && pos[owner] < rq[owner].size()) begin
            done = rq[owner][pos[owner]].last;
            exp_q.push_back('{data: rq[owner][pos[owner]].data, id: ID_W'(owner), hdr: 1'b0});
            pos[owner]++;
         end
         model_last = owner;
      end
   endtask

   function automatic bit any_pending();
      bit p = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   // Requesters: show the queue head; only an owner mid-packet may stall.
   task automatic drive_reqs(input int gap_pct);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rq[i].size() > 0 && !(mid[i] && int'($urandom_range(99)) < gap_pct)) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = rq[i][0].data;
            req_last[i] = rq[i][0].last;
         end else begin
            req_valid[i] = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i] = 1'b0;
         end
      end
   endtask

   task automatic run_traffic(input int dly_max, input int len_min, input int len_max,
                              input int gap_pct, input int budget);
      int cyc, ack_cnt, dly, n_ack, exp_pay, ack_ptr, idx;
      cyc = 0; ack_cnt = 0; n_ack = 0; exp_pay = 0; ack_ptr = 0;
      obs_q.delete();
      build_expect();
      foreach (exp_q[k]) if (!exp_q[k].hdr) exp_pay++;
      dly = int'($urandom_range(dly_max));
      tx_ack = 1'b0;
      drive_reqs(gap_pct);
      do begin
         tick();
         cyc++;
         if (req_ack != '0) begin
            chk("req_ack_onehot", $countones(req_ack), 1);
            chk("req_ack_with_rdy", tx_rdy, 1);
            idx = 0;
            for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) idx = i;
            while (ack_ptr < exp_q.size() && exp_q[ack_ptr].hdr) ack_ptr++;
            if (ack_ptr < exp_q.size()) begin
               chk("req_ack_owner", idx, exp_q[ack_ptr].id);
               chk("req_ack_data", tx_data, exp_q[ack_ptr].data);
            end else begin
               chk("req_ack_extra", 1, 0);
            end
            ack_ptr++;
            n_ack++;
            if (rq[idx].size() > 0) begin
               mid[idx] = !rq[idx][0].last;
               void'(rq[idx].pop_front());
            end
         end
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) tx_ack = 1'b0;
         end else if (tx_rdy) begin
            if (dly > 0) dly--;
            else begin
               obs_q.push_back('{data: tx_data, id: grant_id, hdr: 1'b0});
               tx_ack  = 1'b1;
               ack_cnt = int'($urandom_range(len_max, len_min));
               dly     = int'($urandom_range(dly_max));
            end
         end
         drive_reqs(gap_pct);
      end while (cyc < budget && (busy || tx_ack || any_pending()));
      chk("traffic_timeout", cyc < budget, 1);
      chk("ack_count", n_ack, exp_pay);
      chk("xfer_count", obs_q.size(), exp_q.size());
      pay_q.delete();
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         chk("xfer_data", obs_q[k].data, exp_q[k].data);
         chk("xfer_owner", obs_q[k].id, exp_q[k].id);
         if (!exp_q[k].hdr) pay_q.push_back(obs_q[k]);
      end
   endtask

   vec_t       vt [11];
   logic [7:0] lock_exp [4];
   int         n, np, len;

   initial begin
      vt[0]  = '{4'b0100, 32'h0041_0000, 2'd2, 8'h41};
      vt[1]  = '{4'b0101, 32'h0062_0061, 2'd0, 8'h61};
      vt[2]  = '{4'b1111, 32'h7473_7271, 2'd1, 8'h72};
      vt[3]  = '{4'b1001, 32'h8400_0081, 2'd3, 8'h84};
      vt[4]  = '{4'b0010, 32'h0000_9200, 2'd1, 8'h92};
      vt[5]  = '{4'b1101, 32'hA4A3_00A1, 2'd2, 8'hA3};
      vt[6]  = '{4'b0001, 32'h0000_00B1, 2'd0, 8'hB1};
      vt[7]  = '{4'b0001, 32'h0000_00C1, 2'd0, 8'hC1};
      vt[8]  = '{4'b1110, 32'hD4D3_D200, 2'd1, 8'hD2};
      vt[9]  = '{4'b1000, 32'hE400_0000, 2'd3, 8'hE4};
      vt[10] = '{4'b1011, 32'hF400_F2F1, 2'd0, 8'hF1};
      lock_exp = '{8'h11, 8'h22, 8'h33, 8'h77};

      do_reset();

      // Single-byte arbitrations from IDLE, carrying last_grant across vectors.
      for (int v = 0; v < 11; v++) begin
         req_valid = vt[v].mask; req_data = vt[v].data; req_last = '1;
         tick();
         chk("tbl_busy", busy, 1);
         chk("tbl_early_rdy", tx_rdy, 0);
         chk("tbl_grant", grant_id, vt[v].exp_id);
         if (HDR_EN) begin
            tick();
            chk("tbl_hdr_rdy", tx_rdy, 1);
            chk("tbl_hdr", tx_data, 8'hA0 | 8'(vt[v].exp_id));
            chk("tbl_hdr_noack", req_ack, 0);
            tx_ack = 1'b1; tick(); tx_ack = 1'b0; tick();
         end
         tick();
         chk("tbl_rdy", tx_rdy, 1);
         chk("tbl_data", tx_data, vt[v].exp_byte);
         chk("tbl_ack", req_ack, 4'b0001 << vt[v].exp_id);
         req_valid = '0;
         tx_ack = 1'b1;
         tick();
         chk("tbl_rdy_drop", tx_rdy, 0);
         chk("tbl_ack_pulse", req_ack, 0);
         tx_ack = 1'b0;
         tick();
         chk("tbl_idle", busy, 0);
      end

      // Spurious tx_ack in IDLE does nothing.
      tx_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_ack_busy", busy, 0);
         chk("idle_ack_rdy", tx_rdy, 0);
      end
      tx_ack = 1'b0;

      // Packet lock: requester 0 sends three bytes while requester 1 waits.
      do_reset();
      rq[0].push_back('{8'h11, 1'b0}); rq[0].push_back('{8'h22, 1'b0});
      rq[0].push_back('{8'h33, 1'b1}); rq[1].push_back('{8'h77, 1'b1});
      run_traffic(2, 1, 3, 30, 1000);
      chk("lock_count", pay_q.size(), 4);
      for (int k = 0; k < 4 && k < pay_q.size(); k++) begin
         chk("lock_data", pay_q[k].data, lock_exp[k]);
         chk("lock_owner", pay_q[k].id, (k < 3) ? 0 : 1);
      end

      // Round robin with all requesters continuously valid.
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NUM_REQ; i++) rq[i].push_back('{8'hAA + 8'(17*i), 1'b1});
      run_traffic(1, 1, 2, 0, 1000);
      chk("rr_count", pay_q.size(), 8);
      for (int k = 0; k < 8 && k < pay_q.size(); k++) begin
         chk("rr_owner", pay_q[k].id, k % 4);
         chk("rr_data", pay_q[k].data, 8'hAA + 8'(17*(k % 4)));
      end

      // Long ack: five-cycle ack per byte must not skip or repeat bytes.
      do_reset();
      rq[2].push_back('{8'h5C, 1'b0}); rq[2].push_back('{8'h5D, 1'b1});
      run_traffic(0, 5, 5, 0, 500);
      chk("long_count", pay_q.size(), 2);
      if (pay_q.size() == 2) begin
         chk("long_b0", pay_q[0].data, 8'h5C);
         chk("long_b1", pay_q[1].data, 8'h5D);
      end

      // Reset while byte 2 of 3 waits for its ack.
      do_reset();
      req_valid = 4'b0001; req_data = 32'h11; req_last = 4'b0000;
      wait_rdy("mp_rdy1", n);
      if (HDR_EN) begin
         chk("mp_hdr", tx_data, 8'hA0);
         tx_ack = 1'b1; tick(); tx_ack = 1'b0;
         wait_rdy("mp_rdy1p", n);
      end
      chk("mp_byte1", tx_data, 8'h11);
      chk("mp_ack1", req_ack, 4'b0001);
      req_data = 32'h22;
      tx_ack = 1'b1; tick(); tx_ack = 1'b0;
      wait_rdy("mp_rdy2", n);
      chk("ack_fall_latency", n, 2);
      chk("mp_byte2", tx_data, 8'h22);
      req_data = 32'h33; req_last = 4'b0001;
      rst = 1'b1;
      tick();
      chk("mp_rst_rdy", tx_rdy, 0);
      chk("mp_rst_busy", busy, 0);
      chk("mp_rst_grant", grant_id, 0);
      rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      model_last = NUM_REQ - 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mp_no_ack", req_ack, 0);
         chk("mp_idle", busy, 0);
      end
      rq[1].push_back('{8'h5A, 1'b1});
      run_traffic(1, 1, 2, 0, 500);
      if (pay_q.size() > 0) chk("mp_next_owner", pay_q[0].id, 1);

`ifdef UART_TX_ARB_HEADER_EN
      // Header precedes the payload and earns no req_ack.
      do_reset();
      rq[3].push_back('{8'h55, 1'b1});
      run_traffic(0, 1, 1, 0, 200);
      chk("hdr_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("hdr_byte", obs_q[0].data, 8'hA3);
         chk("hdr_payload", obs_q[1].data, 8'h55);
      end
`endif

      // Randomized packet traffic, model state carried across rounds.
      do_reset();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            np = int'($urandom_range(3));
            for (int p = 0; p < np; p++) begin
               len = int'($urandom_range(4, 1));
               for (int b = 0; b < len; b++)
                  rq[i].push_back('{data: 8'($urandom), last: (b == len - 1)});
            end
         end
         run_traffic(3, 1, 4, 25, 4000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit channel (tx_data/tx_rdy/tx_ack handshake) between NUM_REQ byte-stream requesters.
- Round-robin grant, locked for a whole packet: a requester keeps the channel until it sends the byte flagged last.
- Sits between on-board producers (command responders, status reporters) and the uart transmit side, in the uart clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant index width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  uart clock domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on its req_data slice.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its packet.
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i consumed.
- tx_data  out  8  byte to the uart transmitter.
- tx_rdy  out  1  tx_data valid; held until tx_ack.
- tx_ack  in  1  uart accepted tx_data; may stay high for several cycles.
- busy  out  1  high while a packet is in progress (state != IDLE).
- grant_id  out  ID_W  index of the current owner; holds the last owner in IDLE.

Behaviour:
- Reset values: tx_rdy=0, tx_data=0, req_ack=0, busy=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), state=IDLE.
- States: IDLE, LOAD, WAIT_ACK, WAIT_LOW.
- IDLE:
  - If any req_valid, pick the first requester with req_valid set, searching from last_grant+1 upward with wrap at NUM_REQ.
  - Register grant_id, then go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - If req_valid[grant_id]: tx_data<=slice, tx_rdy<=1, latch last_flag<=req_last[grant_id], pulse req_ack[grant_id] for exactly 1 cycle, go to WAIT_ACK.
  - Otherwise stay in LOAD. The channel stays locked and other requesters are ignored.
- WAIT_ACK: hold tx_rdy and tx_data stable. On tx_ack=1: tx_rdy<=0, go to WAIT_LOW.
- WAIT_LOW: wait for tx_ack=0, so a single long ack is never counted twice. Then:
  - If last_flag: last_grant<=grant_id, go to IDLE.
  - Otherwise go to LOAD.
- Latency:
  - IDLE request to tx_rdy high: 2 cycles (arbitrate, load).
  - tx_ack fall to the next tx_rdy of the same packet: 2 cycles.
- Requesters present a new byte only after seeing req_ack. req_valid staying high in the cycle after req_ack means the next byte.
- At most one req_ack bit is high in any cycle. req_ack is never asserted toward a non-granted requester.
- Simultaneous requests: a strict rotating priority guarantees no starvation. With all requesters continuously valid, packets are served in order 0,1,2,3,0,...
- Single-requester case: the same requester may be re-granted back-to-back.
- A single-byte packet (req_last=1 on the first byte) is legal.
- tx_ack=1 while tx_rdy=0 in IDLE or LOAD is ignored.
- Reset mid-packet: returns to IDLE next cycle, tx_rdy drops immediately, the partial packet is abandoned with no further req_ack, and last_grant returns to NUM_REQ-1.

Optional Feature:
- Macro: UART_TX_ARB_HEADER_EN.
- When defined:
  - An extra state HDR sits between IDLE and LOAD.
  - HDR sends a header byte {4'hA, 1'b0, grant_id zero-extended to 3 bits} with tx_rdy and waits for the full tx_ack/WAIT_LOW cycle.
  - No req_ack is generated for the header.
  - After the header, go to LOAD.
  - Latency from IDLE request to the first payload tx_rdy becomes 2 cycles plus one full header handshake.
- When undefined: no header, and the state encoding omits HDR.

Test Plan:
- Reset then a single request: req_valid=4'b0100, data 8'h41 with last=1. Expect grant_id=2, tx_data=8'h41, tx_rdy high 2 cycles after the request; 1 ack pulse on req_ack[2]; tx_rdy=0 the cycle after tx_ack; busy=0 after tx_ack falls.
- Packet lock: req 0 sends 3 bytes (11,22,33, last on 33) while req 1 is valid throughout. Expect tx_data sequence 11,22,33 with grant_id=0, then req 1's byte; no req_ack[1] before 33 is acknowledged.
- Round robin: all four requesters valid with 1-byte packets AA,BB,CC,DD, repeated twice. Expect owner order 0,1,2,3,0,1,2,3.
- Long ack: tx_ack held high for 5 cycles per byte on a 2-byte packet. Expect exactly 2 req_ack pulses and 2 transfers, with no skipped or duplicated byte.
- Reset mid-packet: assert rst while in WAIT_ACK on byte 2 of 3. Expect tx_rdy=0 and busy=0 the next cycle; the next request from requester 1 wins before requester 0.
- With UART_TX_ARB_HEADER_EN, requester 3 sends 8'h55 (last). Expect tx_data 8'hA3 then 8'h55, and a single req_ack[3] pulse coinciding with the 8'h55 load.
